// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan-code decoder: pops bytes from an upstream receive FIFO, folds
// E0/F0 prefixes into a single key event, tracks shift/ctrl/caps state and
// presents each event (with optional ASCII translation) until acknowledged.
module ps2_scancode_decoder #(
  parameter bit ASCII_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] kbd_data,
  input  logic       kbd_ready,
  output logic       kbd_nextdata_n,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_release,
  output logic [7:0] key_ascii,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       shift_on,
  output logic       ctrl_on,
  output logic       caps_on
);

  typedef enum logic [2:0] {IDLE, POP, SETTLE, DECODE, HOLD} state_t;

  state_t     state, state_next;
  logic [7:0] byte_r;
  logic       ext_r, brk_r;
  logic       lshift_r, rshift_r, caps_held_r;
  logic [7:0] ascii_next;

  logic is_prefix;
  assign is_prefix = (byte_r == 8'hE0) || (byte_r == 8'hF0);
  assign shift_on  = lshift_r | rshift_r;

  // Lowercase ASCII for letter scan codes, 0 for anything else.
  function automatic logic [7:0] letter_char(input logic [7:0] code);
    case (code)
      8'h1C: letter_char = "a";  8'h32: letter_char = "b";
      8'h21: letter_char = "c";  8'h23: letter_char = "d";
      8'h24: letter_char = "e";  8'h2B: letter_char = "f";
      8'h34: letter_char = "g";  8'h33: letter_char = "h";
      8'h43: letter_char = "i";  8'h3B: letter_char = "j";
      8'h42: letter_char = "k";  8'h4B: letter_char = "l";
      8'h3A: letter_char = "m";  8'h31: letter_char = "n";
      8'h44: letter_char = "o";  8'h4D: letter_char = "p";
      8'h15: letter_char = "q";  8'h2D: letter_char = "r";
      8'h1B: letter_char = "s";  8'h2C: letter_char = "t";
      8'h3C: letter_char = "u";  8'h2A: letter_char = "v";
      8'h1D: letter_char = "w";  8'h22: letter_char = "x";
      8'h35: letter_char = "y";  8'h1A: letter_char = "z";
      default: letter_char = 8'h00;
    endcase
  endfunction

  // Digit-row ASCII (plain or shifted symbol), 0 if not a digit key.
  function automatic logic [7:0] digit_char(input logic [7:0] code, input logic shifted);
    case (code)
      8'h45: digit_char = shifted ? ")" : "0";
      8'h16: digit_char = shifted ? "!" : "1";
      8'h1E: digit_char = shifted ? "@" : "2";
      8'h26: digit_char = shifted ? "#" : "3";
      8'h25: digit_char = shifted ? "$" : "4";
      8'h2E: digit_char = shifted ? "%" : "5";
      8'h36: digit_char = shifted ? "^" : "6";
      8'h3D: digit_char = shifted ? "&" : "7";
      8'h3E: digit_char = shifted ? "*" : "8";
      8'h46: digit_char = shifted ? "(" : "9";
      default: digit_char = 8'h00;
    endcase
  endfunction

  generate
    if (ASCII_EN) begin : g_ascii
      logic [7:0] letter, digit;
      // ASCII translation using modifier state from before this event.
      always_comb begin
        ascii_next = 8'h00;
        letter     = letter_char(byte_r);
        digit      = digit_char(byte_r, shift_on);
        if (!brk_r && !ext_r) begin
          if (letter != 8'h00) begin
            if (ctrl_on)                 ascii_next = letter & 8'h1F;
            else if (shift_on ^ caps_on) ascii_next = letter - 8'h20;
            else                         ascii_next = letter;
          end else if (digit != 8'h00) begin
            ascii_next = digit;
          end else begin
            case (byte_r)
              8'h29:   ascii_next = 8'h20;
              8'h5A:   ascii_next = 8'h0D;
              8'h66:   ascii_next = 8'h08;
              8'h0D:   ascii_next = 8'h09;
              default: ascii_next = 8'h00;
            endcase
          end
        end else if (!brk_r && ext_r && byte_r == 8'h5A) begin
          ascii_next = 8'h0D;
        end
      end
    end else begin : g_no_ascii
      assign ascii_next = '0;
    end
  endgenerate

  // Next-state logic and pop strobe; the strobe is masked while in reset.
  always_comb begin
    state_next     = state;
    kbd_nextdata_n = (state != POP) || rst;
    case (state)
      IDLE:    if (kbd_ready && !key_valid) state_next = POP;
      POP:     state_next = SETTLE;
      SETTLE:  state_next = DECODE;
      DECODE:  state_next = is_prefix ? IDLE : HOLD;
      HOLD:    if (key_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Byte capture, prefix flags, event outputs and modifier tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_r       <= '0;
      ext_r        <= 1'b0;
      brk_r        <= 1'b0;
      key_code     <= '0;
      key_extended <= 1'b0;
      key_release  <= 1'b0;
      key_ascii    <= '0;
      key_valid    <= 1'b0;
      lshift_r     <= 1'b0;
      rshift_r     <= 1'b0;
      ctrl_on      <= 1'b0;
      caps_on      <= 1'b0;
      caps_held_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (kbd_ready && !key_valid) byte_r <= kbd_data;
        DECODE: begin
          if (byte_r == 8'hE0) begin
            ext_r <= 1'b1;
          end else if (byte_r == 8'hF0) begin
            brk_r <= 1'b1;
          end else begin
            key_code     <= byte_r;
            key_extended <= ext_r;
            key_release  <= brk_r;
            key_ascii    <= ascii_next;
            key_valid    <= 1'b1;
            ext_r        <= 1'b0;
            brk_r        <= 1'b0;
            if (byte_r == 8'h12) lshift_r <= !brk_r;
            if (byte_r == 8'h59) rshift_r <= !brk_r;
            if (byte_r == 8'h14) ctrl_on  <= !brk_r;
            // Caps toggles only on the first make after a break, so typematic
            // repeats of a held key leave it alone.
            if (byte_r == 8'h58) begin
              if (brk_r) begin
                caps_held_r <= 1'b0;
              end else begin
                if (!caps_held_r) caps_on <= !caps_on;
                caps_held_r <= 1'b1;
              end
            end
          end
        end
        HOLD: if (key_ack) key_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ps2_scancode_decoder.md
PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 Parameter: ASCII_EN, 1, when 0 key_ascii SHALL be tied to 8'h00 and the lookup table omitted.
REQ-002 clk  input  1  system clock; all state SHALL update on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 kbd_data  input  8  scan-code byte at the head of the upstream PS/2 receive FIFO.
REQ-005 kbd_ready  input  1  upstream FIFO non-empty.
REQ-006 kbd_nextdata_n  output  1  active-low pop strobe to the upstream FIFO.
REQ-007 key_code  output  8  final byte of the decoded key event.
REQ-008 key_extended  output  1  event was prefixed by 8'hE0.
REQ-009 key_release  output  1  event was prefixed by 8'hF0 (break).
REQ-010 key_ascii  output  8  ASCII of event; 8'h00 if non-printable or release.
REQ-011 key_valid  output  1  event outputs valid; held until acknowledged.
REQ-012 key_ack  input  1  consumer accepts event.
REQ-013 shift_on, ctrl_on, caps_on  output  1 each  current modifier state.

Function
REQ-014 FSM states: IDLE, POP, SETTLE, DECODE, HOLD.
REQ-015 IDLE: if kbd_ready=1 and key_valid=0, latch kbd_data into byte register, go POP; else stay.
REQ-016 POP: kbd_nextdata_n SHALL be 0 for exactly this one cycle; go SETTLE. In all other states it SHALL be 1.
REQ-017 SETTLE: one idle cycle so upstream ready/pointer settle; go DECODE; no second pop of the same byte SHALL ever occur.
REQ-018 DECODE, byte 8'hE0: set ext flag, go IDLE, no event.
REQ-019 DECODE, byte 8'hF0: set brk flag, go IDLE, no event.
REQ-020 DECODE, any other byte: load key_code=byte, key_extended=ext, key_release=brk, key_ascii per REQ-024..027, assert key_valid, clear ext and brk, update modifiers (REQ-022), go HOLD.
REQ-021 HOLD: key_valid=1 and all event outputs stable until a cycle with key_ack=1; in that cycle key_valid clears and FSM goes IDLE. key_ack while key_valid=0 SHALL be ignored.
REQ-022 Modifiers: shift_on = left(12) or right(59) shift held, tracked independently; ctrl_on = 14 held (extended or not); make sets, break clears.
REQ-023 caps_on SHALL toggle on make of 58 only when the previous 58 event was a break (typematic repeats do not toggle); a caps_held flag tracks this.
REQ-024 Letters (1C..1A set, a-z): lowercase when shift_on xor caps_on = 0, else uppercase; modifier value used is the state before this event's update.
REQ-025 Digits 45,16,1E,26,25,2E,36,3D,3E,46 -> '0'..'9' unshifted; shifted -> ')','!','@','#','$','%','^','&','*','('. caps_on SHALL not affect digits.
REQ-026 29->8'h20, 5A->8'h0D (also with E0), 66->8'h08, 0D->8'h09; all other codes, all other extended codes, and all release events -> 8'h00.
REQ-027 ctrl_on=1 with a letter SHALL give ASCII letter&8'h1F (e.g. ctrl-c -> 8'h03).
REQ-028 Sequence E0 F0 xx SHALL yield one event with extended=1, release=1; F0 E0 xx likewise.
REQ-029 Backpressure: while key_valid=1 no pop SHALL occur; bytes accumulate upstream.
REQ-030 Pop-to-pop spacing SHALL be >= 4 cycles; byte-to-event latency 4 cycles (IDLE->key_valid).

Reset
REQ-031 With rst=1 at a clock edge: state=IDLE, kbd_nextdata_n=1, key_valid=0, key_code=0, key_ascii=0, key_extended=0, key_release=0, ext=brk=0, shift_on=ctrl_on=caps_on=caps_held=0.
REQ-032 Reset mid-sequence (e.g. after E0 or F0, or in HOLD) SHALL discard the partial/pending event; no pop SHALL be issued in the reset cycle.

Verification
REQ-033 FIFO bytes 1C, F0 1C, ack each -> events {1C,rel0,ascii 61}, {1C,rel1,ascii 00}; exactly 3 pops, each 1 cycle low.
REQ-034 12, 1C, F0 12, 1C -> ascii 41 then 61; shift_on 1 then 0.
REQ-035 58,58,58,F0 58, 23 -> caps_on=1 after first 58 only; 23 yields 44; then 58,F0 58 -> caps_on=0.
REQ-036 E0 F0 75 -> one event key_code 75, extended 1, release 1, ascii 00; E0 5A -> ascii 0D.
REQ-037 Withhold key_ack 50 cycles with 3 bytes queued -> key_valid held, outputs stable, kbd_nextdata_n stays 1; ack releases next event 4 cycles later.
REQ-038 rst asserted one cycle after E0 consumed, then 1C -> event extended=0, all modifiers 0.
